// File: rtl/serpent_key_sched.sv
// Serpent key schedule: pads the user key, runs the prekey recurrence and
// streams the 33 bitsliced-S-box round keys into the round-key memory.
module serpent_key_sched #(
  parameter logic [31:0] PHI      = 32'h9E3779B9,
  parameter int          NUM_KEYS = 33
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [255:0] i_key,
  input  logic [1:0]   i_key_len,
  output logic         o_write_en,
  output logic [5:0]   o_addr,
  output logic [127:0] o_key,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic {IDLE, GEN} state_t;

  localparam logic [7:0] LAST = 8'(4 * NUM_KEYS - 1);

  state_t        state;
  logic [7:0]    cnt;
  logic [31:0]   w [8];
  logic [255:0]  pad_key;
  logic [31:0]   fb;
  logic [31:0]   w_new;
  logic [2:0]    sel;
  logic [63:0]   tbl;
  logic [127:0]  rk;

  // Each table packs entry v into bits [4v+3:4v].
  function automatic logic [63:0] sbox_tbl(input logic [2:0] s);
    logic [63:0] t;
    unique case (s)
      3'd0: t = 64'hC90724DEB56A1F83;
      3'd1: t = 64'h43D68EB1A50972CF;
      3'd2: t = 64'h25B04E1DFAC39768;
      3'd3: t = 64'hE57A421D369C8BF0;
      3'd4: t = 64'hD7E9A4526B0C38F1;
      3'd5: t = 64'h176D8E30C9A4B25F;
      3'd6: t = 64'h0A3DF19EB6485C27;
      3'd7: t = 64'h6539AC47B28E0FD1;
    endcase
    return t;
  endfunction

  always_comb begin
    pad_key = i_key;
    unique case (i_key_len)
      2'b00:   pad_key = {127'd0, 1'b1, i_key[127:0]};
      2'b01:   pad_key = {63'd0, 1'b1, i_key[191:0]};
      default: pad_key = i_key;
    endcase
  end

  always_comb begin
    fb    = w[0] ^ w[3] ^ w[5] ^ w[7] ^ PHI ^ {24'd0, cnt};
    w_new = {fb[20:0], fb[31:21]};
    sel   = 3'd3 - cnt[4:2];
    tbl   = sbox_tbl(sel);
    rk    = '0;
    // Bit j of the four newest words forms one nibble, oldest word as LSB.
    for (int j = 0; j < 32; j++) begin
      logic [3:0] nib;
      logic [3:0] sv;
      nib = {w_new[j], w[7][j], w[6][j], w[5][j]};
      sv  = tbl[{nib, 2'b00} +: 4];
      for (int b = 0; b < 4; b++) begin
        rk[32*b + j] = sv[b];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      o_write_en <= 1'b0;
      o_addr     <= '0;
      o_key      <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      for (int k = 0; k < 8; k++) w[k] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          o_write_en <= 1'b0;
          if (i_start) begin
            for (int k = 0; k < 8; k++) w[k] <= pad_key[32*k +: 32];
            cnt    <= '0;
            o_done <= 1'b0;
            o_busy <= 1'b1;
            state  <= GEN;
          end
        end
        GEN: begin
          for (int k = 0; k < 7; k++) w[k] <= w[k+1];
          w[7]       <= w_new;
          cnt        <= cnt + 8'd1;
          o_write_en <= (cnt[1:0] == 2'b11);
          if (cnt[1:0] == 2'b11) begin
            o_key  <= rk;
            o_addr <= cnt[7:2];
          end
          if (cnt == LAST) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
